// File: rtl/lb_master_pkg.sv
// ---------------------------------------------------------------------------
// lb_master_pkg
// Shared constants and types for the Marble local bus initiator.
//   LB_AW     : local bus address width
//   LB_DW     : local bus data width
//   LB_RW     : width of one response buffer entry
//   lb_resp_t : response entry {addr, data}
// ---------------------------------------------------------------------------
package lb_master_pkg;

  localparam int LB_AW = 24;
  localparam int LB_DW = 32;
  localparam int LB_RW = LB_AW + LB_DW;

  typedef struct packed {
    logic [LB_AW-1:0] addr;
    logic [LB_DW-1:0] data;
  } lb_resp_t;

endpackage

// File: rtl/lb_master_rfifo.sv
// ---------------------------------------------------------------------------
// lb_master_rfifo
// Synchronous first-word-fall-through FIFO holding lb_resp_t entries,
// depth 2**aw. The head entry is presented on rd_data whenever empty is low.
// The caller guarantees no push into a full FIFO and no pop from an empty one.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write push_data at the tail
//   push_data    : entry to write
//   pop          : discard the head entry
//   rd_data      : head entry (valid while empty is low)
//   empty        : no entries stored
//   occupancy    : number of stored entries (0 .. 2**aw)
// ---------------------------------------------------------------------------
module lb_master_rfifo
  import lb_master_pkg::*;
#(
  parameter int aw = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  lb_resp_t      push_data,
  input  logic          pop,
  output lb_resp_t      rd_data,
  output logic          empty,
  output logic [aw:0]   occupancy
);

  localparam int          DEPTH   = 1 << aw;
  localparam logic [aw:0] PTR_ONE = {{aw{1'b0}}, 1'b1};

  lb_resp_t    mem_r [DEPTH];
  logic [aw:0] wr_ptr_r;
  logic [aw:0] rd_ptr_r;

  // Storage array and tail pointer: written on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {LB_RW{1'b0}};
      end
      wr_ptr_r <= {(aw+1){1'b0}};
    end else if (push) begin
      mem_r[wr_ptr_r[aw-1:0]] <= push_data;
      wr_ptr_r                <= wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Head pointer: advances on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {(aw+1){1'b0}};
    end else if (pop) begin
      rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign rd_data   = mem_r[rd_ptr_r[aw-1:0]];
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign occupancy = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/lb_marble_master.sv
// ---------------------------------------------------------------------------
// lb_marble_master
// Local bus initiator for the Marble local bus slave. Each accepted request
// becomes a one-cycle control_strobe transaction. Reads travel an rd_lat-deep
// pipeline alongside the slave's fixed read latency and their {addr, data}
// results are returned in order through a small FWFT response buffer.
// A credit counter (buffer occupancy + reads in flight) throttles req_ready so
// the buffer can never overflow.
//
// Build option:
//   LB_MASTER_WRITE_ACK_EN : when defined, writes also consume a credit, pass
//                            through the pipeline and return {addr, wdata} as
//                            a response, in order with reads.
//
// Parameters:
//   rd_lat   : cycles from the strobe cycle to valid slave data_in (>= 1)
//   rfifo_aw : log2 of the response buffer depth (>= 1)
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake
//   req_write             : 1 = write, 0 = read
//   req_addr, req_data    : request address and write data
//   control_strobe        : one-cycle transaction strobe to the slave
//   control_rd            : read qualifier
//   addr, data_out        : address / write data to the slave
//   data_in               : read data from the slave
//   resp_valid/resp_ready : response handshake
//   resp_addr, resp_data  : response address and data
//   busy                  : reads (or acked writes) in flight or buffered
//   txn_count             : wrapping count of issued strobes
// ---------------------------------------------------------------------------
module lb_marble_master
  import lb_master_pkg::*;
#(
  parameter int rd_lat   = 2,
  parameter int rfifo_aw = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [LB_AW-1:0] req_addr,
  input  logic [LB_DW-1:0] req_data,
  output logic             control_strobe,
  output logic             control_rd,
  output logic [LB_AW-1:0] addr,
  output logic [LB_DW-1:0] data_out,
  input  logic [LB_DW-1:0] data_in,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [LB_AW-1:0] resp_addr,
  output logic [LB_DW-1:0] resp_data,
  output logic             busy,
  output logic [15:0]      txn_count
);

  localparam int                DEPTH     = 1 << rfifo_aw;
  localparam logic [rfifo_aw:0] CRED_MAX  = (rfifo_aw+1)'(DEPTH);
  localparam logic [rfifo_aw:0] CRED_ONE  = {{rfifo_aw{1'b0}}, 1'b1};
  localparam logic [rfifo_aw:0] CRED_ZERO = {(rfifo_aw+1){1'b0}};

  // Handshake decode
  logic accept_s;
  logic consume_s;
  logic pop_s;

  // Bus drive registers
  logic             ready_en_r;
  logic             strobe_r;
  logic             rd_r;
  logic [LB_AW-1:0] addr_r;
  logic [LB_DW-1:0] data_out_r;

  // Response pipeline
  logic                 pipe_in_vld_s;
  logic [rd_lat-1:0]    pipe_vld_r;
  logic [LB_AW-1:0]     pipe_addr_r [rd_lat];
`ifdef LB_MASTER_WRITE_ACK_EN
  logic [rd_lat-1:0]    pipe_wr_r;
  logic [LB_DW-1:0]     pipe_wdat_r [rd_lat];
`endif

  // Response buffer interface
  lb_resp_t          push_data_s;
  lb_resp_t          fifo_rd_s;
  logic              push_s;
  logic              room_s;
  logic              fifo_empty_s;
  logic [rfifo_aw:0] occ_s;

  // Status
  logic [rfifo_aw:0] credits_r;
  logic [rfifo_aw:0] credits_nxt_s;
  logic              busy_r;
  logic [15:0]       txn_count_r;

  assign accept_s = req_valid & req_ready;
  assign pop_s    = resp_valid & resp_ready;

`ifdef LB_MASTER_WRITE_ACK_EN
  assign consume_s     = accept_s;
  assign pipe_in_vld_s = strobe_r;
`else
  assign consume_s     = accept_s & ~req_write;
  assign pipe_in_vld_s = rd_r;
`endif

  // ready_en_r keeps req_ready low through reset and up to the first edge
  // after release; the credit comparison uses registers only.
  assign req_ready = ready_en_r & (credits_r < CRED_MAX);

  // Ready enable: rises on the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Bus drive: strobe for one cycle per accepted request; addr/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_r   <= 1'b0;
      rd_r       <= 1'b0;
      addr_r     <= {LB_AW{1'b0}};
      data_out_r <= {LB_DW{1'b0}};
    end else begin
      strobe_r <= accept_s;
      rd_r     <= accept_s & ~req_write;
      if (accept_s) begin
        addr_r     <= req_addr;
        data_out_r <= req_data;
      end
    end
  end

  // Response pipeline: stage 0 is loaded from the strobe cycle, so the last
  // stage is valid in the same cycle the slave presents data_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r <= {rd_lat{1'b0}};
      for (int i = 0; i < rd_lat; i++) begin
        pipe_addr_r[i] <= {LB_AW{1'b0}};
      end
    end else begin
      pipe_vld_r[0]  <= pipe_in_vld_s;
      pipe_addr_r[0] <= addr_r;
      for (int i = 1; i < rd_lat; i++) begin
        pipe_vld_r[i]  <= pipe_vld_r[i-1];
        pipe_addr_r[i] <= pipe_addr_r[i-1];
      end
    end
  end

`ifdef LB_MASTER_WRITE_ACK_EN
  // Write-acknowledge side pipeline: carries the write flag and written data
  // so the response reports what was actually driven on data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_wr_r <= {rd_lat{1'b0}};
      for (int i = 0; i < rd_lat; i++) begin
        pipe_wdat_r[i] <= {LB_DW{1'b0}};
      end
    end else begin
      pipe_wr_r[0]   <= strobe_r & ~rd_r;
      pipe_wdat_r[0] <= data_out_r;
      for (int i = 1; i < rd_lat; i++) begin
        pipe_wr_r[i]   <= pipe_wr_r[i-1];
        pipe_wdat_r[i] <= pipe_wdat_r[i-1];
      end
    end
  end
`endif

  // Response entry assembly at the pipeline exit.
  always_comb begin
    push_data_s.addr = pipe_addr_r[rd_lat-1];
    push_data_s.data = data_in;
`ifdef LB_MASTER_WRITE_ACK_EN
    if (pipe_wr_r[rd_lat-1]) begin
      push_data_s.data = pipe_wdat_r[rd_lat-1];
    end else begin
      push_data_s.data = data_in;
    end
`endif
  end

  // Credits already prevent overflow; the room term is a second guard so a
  // corrupted credit count cannot overwrite buffered responses.
  assign room_s = (occ_s != CRED_MAX) | pop_s;
  assign push_s = pipe_vld_r[rd_lat-1] & room_s;

  lb_master_rfifo #(
    .aw (rfifo_aw)
  ) u_rfifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .rd_data   (fifo_rd_s),
    .empty     (fifo_empty_s),
    .occupancy (occ_s)
  );

  assign resp_valid = ~fifo_empty_s;
  assign resp_addr  = fifo_rd_s.addr;
  assign resp_data  = fifo_rd_s.data;

  // Credit update: +1 on consuming issue, -1 on pop, unchanged on both.
  always_comb begin
    credits_nxt_s = credits_r;
    case ({consume_s, pop_s})
      2'b10:   credits_nxt_s = credits_r + CRED_ONE;
      2'b01:   credits_nxt_s = credits_r - CRED_ONE;
      default: credits_nxt_s = credits_r;
    endcase
  end

  // Status registers: credit counter, busy flag and transaction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_r   <= CRED_ZERO;
      busy_r      <= 1'b0;
      txn_count_r <= 16'h0000;
    end else begin
      credits_r <= credits_nxt_s;
      busy_r    <= (credits_nxt_s != CRED_ZERO);
      if (strobe_r) begin
        txn_count_r <= txn_count_r + 16'h0001;
      end
    end
  end

  assign control_strobe = strobe_r;
  assign control_rd     = rd_r;
  assign addr           = addr_r;
  assign data_out       = data_out_r;
  assign busy           = busy_r;
  assign txn_count      = txn_count_r;

endmodule

// File: tb/tb_lb_marble_master.sv
// ---------------------------------------------------------------------------
// tb_lb_marble_master
// Directed self-checking bench for lb_marble_master (rd_lat = 2, depth 4).
// A small slave model returns slave_word(addr) two cycles after a read strobe.
// ---------------------------------------------------------------------------
module tb_lb_marble_master;
  import lb_master_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [LB_AW-1:0] req_addr;
  logic [LB_DW-1:0] req_data;
  logic             control_strobe;
  logic             control_rd;
  logic [LB_AW-1:0] addr;
  logic [LB_DW-1:0] data_out;
  logic [LB_DW-1:0] data_in;
  logic             resp_valid;
  logic             resp_ready;
  logic [LB_AW-1:0] resp_addr;
  logic [LB_DW-1:0] resp_data;
  logic             busy;
  logic [15:0]      txn_count;

  int          n_pass;
  int          n_total;
  logic [15:0] exp_txn;

  lb_marble_master #(
    .rd_lat   (2),
    .rfifo_aw (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .control_strobe (control_strobe),
    .control_rd     (control_rd),
    .addr           (addr),
    .data_out       (data_out),
    .data_in        (data_in),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_addr      (resp_addr),
    .resp_data      (resp_data),
    .busy           (busy),
    .txn_count      (txn_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model: read data valid 2 cycles after the strobe cycle.
  function automatic logic [31:0] slave_word(input logic [23:0] a);
    return 32'h48656C6C ^ {8'h00, a};
  endfunction

  logic [1:0]  sl_v;
  logic [23:0] sl_a0;
  logic [23:0] sl_a1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_v  <= 2'b00;
      sl_a0 <= 24'h000000;
      sl_a1 <= 24'h000000;
    end else begin
      sl_v[0] <= control_strobe & control_rd;
      sl_a0   <= addr;
      sl_v[1] <= sl_v[0];
      sl_a1   <= sl_a0;
    end
  end

  assign data_in = sl_v[1] ? slave_word(sl_a1) : 32'hDEADBEEF;

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = 24'h000000;
    req_data   = 32'h00000000;
    resp_ready = 1'b0;
    exp_txn    = 16'h0000;
    repeat (3) @(negedge clk);
    n_total++; if (control_strobe !== 1'b0) $display("FAIL rst_strobe: got %b want 0", control_strobe); else n_pass++;
    n_total++; if (control_rd !== 1'b0) $display("FAIL rst_rd: got %b want 0", control_rd); else n_pass++;
    n_total++; if (addr !== 24'h000000) $display("FAIL rst_addr: got %h want 000000", addr); else n_pass++;
    n_total++; if (data_out !== 32'h00000000) $display("FAIL rst_data_out: got %h want 0", data_out); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else n_pass++;
    n_total++; if (txn_count !== 16'h0000) $display("FAIL rst_txn: got %h want 0", txn_count); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", req_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (req_ready !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_single_write();
    logic seen;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 24'h050001;
    req_data  = 32'h00000001;
    n_total++; if (req_ready !== 1'b1) $display("FAIL wr_ready: got %b want 1", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0;
    n_total++; if (control_strobe !== 1'b1) $display("FAIL wr_strobe: got %b want 1", control_strobe); else n_pass++;
    n_total++; if (control_rd !== 1'b0) $display("FAIL wr_rd: got %b want 0", control_rd); else n_pass++;
    n_total++; if (addr !== 24'h050001) $display("FAIL wr_addr: got %h want 050001", addr); else n_pass++;
    n_total++; if (data_out !== 32'h00000001) $display("FAIL wr_data_out: got %h want 00000001", data_out); else n_pass++;
    @(negedge clk);
    n_total++; if (control_strobe !== 1'b0) $display("FAIL wr_strobe_one_cycle: got %b want 0", control_strobe); else n_pass++;
    n_total++; if (addr !== 24'h050001) $display("FAIL wr_addr_hold: got %h want 050001", addr); else n_pass++;
    exp_txn = exp_txn + 16'h0001;
`ifdef LB_MASTER_WRITE_ACK_EN
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (resp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    n_total++; if (seen !== 1'b1) $display("FAIL wr_ack_seen: got %b want 1", seen); else n_pass++;
    n_total++; if (resp_data !== 32'h00000001) $display("FAIL wr_ack_data: got %h want 00000001", resp_data); else n_pass++;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
`else
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL wr_no_resp: got %b want 0", seen); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL wr_busy: got %b want 0", busy); else n_pass++;
`endif
  endtask

  task automatic test_single_read();
    logic early;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 24'h000000;
    @(negedge clk);
    req_valid = 1'b0;
    n_total++; if (control_strobe !== 1'b1) $display("FAIL rd_strobe: got %b want 1", control_strobe); else n_pass++;
    n_total++; if (control_rd !== 1'b1) $display("FAIL rd_rd: got %b want 1", control_rd); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL rd_busy: got %b want 1", busy); else n_pass++;
    early = resp_valid;
    @(negedge clk);
    early = early | resp_valid;
    @(negedge clk);
    early = early | resp_valid;
    n_total++; if (early !== 1'b0) $display("FAIL rd_resp_early: got %b want 0", early); else n_pass++;
    @(negedge clk);
    n_total++; if (resp_valid !== 1'b1) $display("FAIL rd_resp_cycle4: got %b want 1", resp_valid); else n_pass++;
    n_total++; if (resp_addr !== 24'h000000) $display("FAIL rd_resp_addr: got %h want 000000", resp_addr); else n_pass++;
    n_total++; if (resp_data !== 32'h48656C6C) $display("FAIL rd_resp_data: got %h want 48656C6C", resp_data); else n_pass++;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL rd_popped: got %b want 0", resp_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rd_busy_after: got %b want 0", busy); else n_pass++;
    exp_txn = exp_txn + 16'h0001;
  endtask

  task automatic test_backpressure();
    int idx;
    int strobes;
    int got;
    idx        = 0;
    strobes    = 0;
    got        = 0;
    resp_ready = 1'b0;
    req_write  = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 6) begin
        req_valid = 1'b1;
        req_addr  = 24'(idx);
        if (req_ready) idx++;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (control_strobe) strobes++;
    end
    n_total++; if (strobes != 4) $display("FAIL bp_strobes_held: got %0d want 4", strobes); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", req_ready); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", busy); else n_pass++;
    resp_ready = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (idx < 6) begin
        req_valid = 1'b1;
        req_addr  = 24'(idx);
        if (req_ready) idx++;
      end else begin
        req_valid = 1'b0;
      end
      if (resp_valid) begin
        n_total++; if (resp_addr !== 24'(got)) $display("FAIL bp_order: got %h want %h", resp_addr, 24'(got)); else n_pass++;
        n_total++; if (resp_data !== slave_word(24'(got))) $display("FAIL bp_data: got %h want %h", resp_data, slave_word(24'(got))); else n_pass++;
        got++;
      end
      @(negedge clk);
      if (control_strobe) strobes++;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    n_total++; if (got != 6) $display("FAIL bp_resp_count: got %0d want 6", got); else n_pass++;
    n_total++; if (strobes != 6) $display("FAIL bp_strobes_total: got %0d want 6", strobes); else n_pass++;
    exp_txn = exp_txn + 16'd6;
  endtask

  task automatic test_streaming();
    int   idx;
    int   strobes;
    int   got;
    logic last_busy;
    idx        = 0;
    strobes    = 0;
    got        = 0;
    last_busy  = 1'b0;
    resp_ready = 1'b1;
    req_write  = 1'b0;
    for (int c = 0; c < 300 && got < 32; c++) begin
      if (idx < 32) begin
        req_valid = 1'b1;
        req_addr  = 24'h000100 + 24'(idx);
        if (req_ready) idx++;
      end else begin
        req_valid = 1'b0;
      end
      if (resp_valid) begin
        n_total++; if (resp_addr !== 24'h000100 + 24'(got)) $display("FAIL st_order: got %h want %h", resp_addr, 24'h000100 + 24'(got)); else n_pass++;
        n_total++; if (resp_data !== slave_word(24'h000100 + 24'(got))) $display("FAIL st_data: got %h want %h", resp_data, slave_word(24'h000100 + 24'(got))); else n_pass++;
        got++;
        last_busy = busy;
      end
      @(negedge clk);
      if (control_strobe) strobes++;
    end
    req_valid  = 1'b0;
    n_total++; if (got != 32) $display("FAIL st_resp_count: got %0d want 32", got); else n_pass++;
    n_total++; if (strobes != 32) $display("FAIL st_strobes: got %0d want 32", strobes); else n_pass++;
    n_total++; if (last_busy !== 1'b1) $display("FAIL st_busy_last: got %b want 1", last_busy); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL st_busy_fall: got %b want 0", busy); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL st_drained: got %b want 0", resp_valid); else n_pass++;
    resp_ready = 1'b0;
    exp_txn = exp_txn + 16'd32;
  endtask

  task automatic test_txn_count();
    repeat (2) @(negedge clk);
    n_total++; if (txn_count !== exp_txn) $display("FAIL txn_count: got %h want %h", txn_count, exp_txn); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    logic seen;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = 24'h000020;
    @(negedge clk);
    req_addr   = 24'h000021;
    @(negedge clk);
    req_valid  = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL mf_busy_before: got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (control_strobe !== 1'b0) $display("FAIL mf_strobe: got %b want 0", control_strobe); else n_pass++;
    n_total++; if (txn_count !== 16'h0000) $display("FAIL mf_txn: got %h want 0", txn_count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mf_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL mf_ready: got %b want 0", req_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL mf_no_resp: got %b want 0", seen); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL mf_ready_after: got %b want 1", req_ready); else n_pass++;
    n_total++; if (txn_count !== 16'h0000) $display("FAIL mf_txn_after: got %h want 0", txn_count); else n_pass++;
    resp_ready = 1'b0;
    exp_txn    = 16'h0000;
  endtask

`ifdef LB_MASTER_WRITE_ACK_EN
  task automatic test_write_ack();
    int got;
    got        = 0;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 24'h050002;
    req_data   = 32'h000000AB;
    @(negedge clk);
    req_write  = 1'b0;
    req_addr   = 24'h000004;
    @(negedge clk);
    req_valid  = 1'b0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (resp_valid) begin
        if (got == 0) begin
          n_total++; if (resp_addr !== 24'h050002) $display("FAIL ack_addr0: got %h want 050002", resp_addr); else n_pass++;
          n_total++; if (resp_data !== 32'h000000AB) $display("FAIL ack_data0: got %h want 000000AB", resp_data); else n_pass++;
        end else begin
          n_total++; if (resp_addr !== 24'h000004) $display("FAIL ack_addr1: got %h want 000004", resp_addr); else n_pass++;
          n_total++; if (resp_data !== slave_word(24'h000004)) $display("FAIL ack_data1: got %h want %h", resp_data, slave_word(24'h000004)); else n_pass++;
        end
        got++;
      end
      @(negedge clk);
    end
    n_total++; if (got != 2) $display("FAIL ack_count: got %0d want 2", got); else n_pass++;
    resp_ready = 1'b0;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single_write();
    test_single_read();
    test_backpressure();
    test_streaming();
    test_txn_count();
    test_reset_midflight();
`ifdef LB_MASTER_WRITE_ACK_EN
    test_write_ack();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
